// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver: prescaled digit scan, per-frame input
// snapshot, hex/legacy decode, dp, blank mask, leading-zero suppression, polarity.
module seg_scan_mux #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit POS_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_bus,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  hex_mode,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     pos,
  output logic [7:0]            seg
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]            cnt_q, cnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0]        pos_q, pos_d;
  logic [7:0]               seg_q, seg_d;

  logic [DIGITS-1:0][3:0]   snap_nib_q;
  logic [DIGITS-1:0]        snap_dp_q;
  logic [DIGITS-1:0]        snap_blank_q;
  logic                     snap_hex_q;
  logic                     snap_lz_q;

  logic                     tick;
  logic                     frame_start;
  logic                     live;
  logic [3:0]               cur_nib;
  logic                     cur_dp;
  logic                     cur_blank;
  logic                     cur_hex;
  logic                     suppress;
  logic [DIGITS-1:0]        upper_zero;

  function automatic logic [6:0] decode7(input logic [3:0] nib, input logic hex);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      // Legacy mode: 10 = dash, 11 = blank, 12..15 = segment d only
      4'hA:    s = hex ? 7'h77 : 7'h40;
      4'hB:    s = hex ? 7'h7C : 7'h00;
      4'hC:    s = hex ? 7'h39 : 7'h08;
      4'hD:    s = hex ? 7'h5E : 7'h08;
      4'hE:    s = hex ? 7'h79 : 7'h08;
      4'hF:    s = hex ? 7'h71 : 7'h08;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Prescaler and digit index advance
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    tick        = (cnt_q == CNT_LAST);
    cnt_d       = tick ? '0 : cnt_q + CW'(1);
    idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    frame_start = tick && (idx_d == '0);
  end

  // upper_zero[i] is set when nibbles i..DIGITS-1 of the snapshot are all zero
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run           = run & (snap_nib_q[i] == 4'h0);
      upper_zero[i] = run;
    end
  end

  // Digit 0 decodes from the live bus on the edge that captures the snapshot
  always_comb begin
    live      = (idx_d == '0);
    cur_nib   = live ? data_bus[3:0]  : snap_nib_q[idx_d];
    cur_dp    = live ? dp_in[0]       : snap_dp_q[idx_d];
    cur_blank = live ? blank_mask[0]  : snap_blank_q[idx_d];
    cur_hex   = live ? hex_mode       : snap_hex_q;
    suppress  = !live && snap_lz_q && upper_zero[idx_d];

    seg_d = {cur_dp, suppress ? 7'h00 : decode7(cur_nib, cur_hex)};
    if (cur_blank) seg_d = 8'h00;
    pos_d = DIGITS'(1) << idx_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
      cnt_q        <= '0;
      idx_q        <= IDX_LAST;
      pos_q        <= '0;
      seg_q        <= '0;
      // NOTE: the snapshot is ordinary flops, reset with the rest so the display state is fully defined.
      snap_nib_q   <= '0;
      snap_dp_q    <= '0;
      snap_blank_q <= '0;
      snap_hex_q   <= 1'b0;
      snap_lz_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (tick) begin
        idx_q <= idx_d;
        pos_q <= pos_d;
        seg_q <= seg_d;
      end
      if (frame_start) begin
        snap_nib_q   <= data_bus;
        snap_dp_q    <= dp_in;
        snap_blank_q <= blank_mask;
        snap_hex_q   <= hex_mode;
        snap_lz_q    <= lz_en;
      end
    end
  end

  // Polarity is applied after the registers, so reset values are inverted as well
  assign pos = pos_q ^ {DIGITS{POS_ACTIVE_LOW}};
  assign seg = seg_q ^ {8{SEG_ACTIVE_LOW}};

endmodule
